// File: rtl/beat_gen.sv
// Beat timing generator for the hardwired controller: emits a one-hot W1/W2/W3
// sequence per instruction cycle and counts completed cycles.
module beat_gen #(
  parameter int CNT_W = 16
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             step,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic             cycle_end,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] W1   = 2'd1;
  localparam logic [1:0] W2   = 2'd2;
  localparam logic [1:0] W3   = 2'd3;

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic       qd_q_r;
  logic       start_r;
  logic       stop_pend_r;
  logic       halt_s;
  logic       last_beat_s;

  // Next-beat selection and last-beat detection
  always_comb begin
    next_state_s = state_r;
    last_beat_s  = 1'b0;
    halt_s       = stop | stop_pend_r | step;
    case (state_r)
      IDLE: begin
        if (start_r) next_state_s = W1;
        else         next_state_s = IDLE;
      end
      W1: begin
        if (short) begin
          last_beat_s = 1'b1;
          if (halt_s) next_state_s = IDLE;
          else        next_state_s = W1;
        end else begin
          next_state_s = W2;
        end
      end
      W2: begin
        if (long) begin
          next_state_s = W3;
        end else begin
          last_beat_s = 1'b1;
          if (halt_s) next_state_s = IDLE;
          else        next_state_s = W1;
        end
      end
      W3: begin
        last_beat_s = 1'b1;
        if (halt_s) next_state_s = IDLE;
        else        next_state_s = W1;
      end
      default: begin
        next_state_s = IDLE;
        last_beat_s  = 1'b0;
      end
    endcase
  end

  assign cycle_end = last_beat_s;

  // State, registered beat decode, start/stop tracking and cycle counter
  always_ff @(posedge t3 or posedge clr) begin
    if (clr) begin
      state_r     <= IDLE;
      w1          <= 1'b0;
      w2          <= 1'b0;
      w3          <= 1'b0;
      running     <= 1'b0;
      qd_q_r      <= 1'b0;
      start_r     <= 1'b0;
      stop_pend_r <= 1'b0;
      cycle_cnt   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      w1      <= (next_state_s == W1);
      w2      <= (next_state_s == W2);
      w3      <= (next_state_s == W3);
      running <= (next_state_s != IDLE);
      qd_q_r  <= qd;
      // A qd edge seen while running is dropped, not deferred to the next IDLE
      start_r <= qd & ~qd_q_r & (state_r == IDLE);
      if (next_state_s == IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (stop && (state_r != IDLE)) begin
        stop_pend_r <= 1'b1;
      end else begin
        stop_pend_r <= stop_pend_r;
      end
      if (last_beat_s) begin
        cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cycle_cnt <= cycle_cnt;
      end
    end
  end

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen: expected beat/count pushed on each drive,
// popped and compared after the clock edge.
module tb_beat_gen;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SA = 2'd1;
  localparam logic [1:0] SB = 2'd2;
  localparam logic [1:0] SC = 2'd3;

  logic       t3 = 1'b0;
  logic       clr, qd, step, short, long, stop;
  logic       w1, w2, w3, running, cycle_end;
  logic [3:0] cycle_cnt;

  typedef struct {
    logic [1:0] st;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] ecnt;

  beat_gen #(.CNT_W(4)) dut (
    .t3(t3), .clr(clr), .qd(qd), .step(step), .short(short), .long(long),
    .stop(stop), .w1(w1), .w2(w2), .w3(w3), .running(running),
    .cycle_end(cycle_end), .cycle_cnt(cycle_cnt)
  );

  always #5 t3 = ~t3;

  function automatic logic [3:0] decode(input logic [1:0] s);
    case (s)
      SI:      decode = 4'b0000;
      SA:      decode = 4'b1001;
      SB:      decode = 4'b0101;
      SC:      decode = 4'b0011;
      default: decode = 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One beat: drive inputs, check cycle_end, push expectation, clock, pop and compare
  task automatic tick(input logic q, input logic sh, input logic lg, input logic sp,
                      input logic st, input logic ce, input logic [1:0] nxt);
    exp_t e;
    qd = q; short = sh; long = lg; stop = sp; step = st;
    #1;
    check("cycle_end", {7'd0, cycle_end}, {7'd0, ce});
    if (ce) ecnt = ecnt + 4'd1;
    else    ecnt = ecnt;
    e.st  = nxt;
    e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge t3);
    #1;
    e = exp_q.pop_front();
    check("beats", {4'd0, w1, w2, w3, running}, {4'd0, decode(e.st)});
    check("cycle_cnt", {4'd0, cycle_cnt}, {4'd0, e.cnt});
  endtask

  initial begin
    clr = 1'b1; qd = 1'b0; step = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
    ecnt = 4'd0;
    @(posedge t3);
    #1;
    check("reset_beats", {4'd0, w1, w2, w3, running}, 8'd0);
    check("reset_cnt", {4'd0, cycle_cnt}, 8'd0);
    clr = 1'b0;

    // start, then normal two-beat cycles
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SA);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SA);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SA);

    // short, short+long, long ignored in W1, long cycle with short ignored in W3
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SA);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, SA);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SC);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SA);

    // stop in W1 of a long cycle finishes the cycle, then halts
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SC);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SI);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SA);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SA);

    // single-step: one cycle per qd rise, held qd and qd pulses while running ignored
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SB);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SA);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, SI);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SA);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SB);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SI);

    // asynchronous clear in the middle of W2
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SA);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB);
    #2;
    clr = 1'b1;
    #1;
    check("async_clr_beats", {4'd0, w1, w2, w3, running}, 8'd0);
    check("async_clr_cnt", {4'd0, cycle_cnt}, 8'd0);
    qd = 1'b0;
    @(posedge t3);
    #1;
    clr = 1'b0;
    ecnt = 4'd0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SA);

    // sixteen normal cycles wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SA);
    end
    check("wrap_cnt_zero", {4'd0, cycle_cnt}, 8'd0);
    check("wrap_beat_w1", {4'd0, w1, w2, w3, running}, 8'b0000_1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
